// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V
// funct3 access codes and the byte-strobe mask for an access size.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ERR  = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // funct3[1:0] encodes log2 of the access size for every legal code.
    function automatic logic [7:0] strb_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and data-bus signals of the load/store unit,
// bundled so the unit sees the slave view and a driver the master view.
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    logic                  data_read;
    logic                  data_write;
    logic [ADDR_W-1:0]     data_adr_o;
    logic [DATA_W-1:0]     data_bus_o;
    logic [DATA_W/8-1:0]   data_sel_o;
    logic [DATA_W-1:0]     data_bus_i;
    logic                  data_good;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  data_bus_i, data_good,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output data_read, data_write, data_adr_o, data_bus_o, data_sel_o
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output data_bus_i, data_good,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  data_read, data_write, data_adr_o, data_bus_o, data_sel_o
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment: request legality, store lane replication and
// byte enables, and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic              req_write_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [OFF_W-1:0]  req_off_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              req_ok_o,
    output logic [DATA_W-1:0] st_bus_o,
    output logic [NB-1:0]     st_sel_o,

    input  logic [2:0]        ld_funct3_i,
    input  logic [OFF_W-1:0]  ld_off_i,
    input  logic [DATA_W-1:0] ld_bus_i,
    output logic [DATA_W-1:0] ld_data_o
);

    localparam bit IS64 = (DATA_W == 64);

    logic              f3_ok;
    logic              misaligned;
    logic [OFF_W-1:0]  amask;
    logic [7:0]        mask8;
    logic [DATA_W-1:0] shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;

    always_comb begin
        f3_ok = 1'b0;
        if (req_write_i) begin
            case (req_funct3_i)
                F3_B, F3_H, F3_W: f3_ok = 1'b1;
                F3_D:             f3_ok = IS64;
                default:          f3_ok = 1'b0;
            endcase
        end else begin
            case (req_funct3_i)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_ok = 1'b1;
                F3_D, F3_WU:                    f3_ok = IS64;
                default:                        f3_ok = 1'b0;
            endcase
        end
        amask      = OFF_W'((4'd1 << req_funct3_i[1:0]) - 4'd1);
        misaligned = |(req_off_i & amask);
        req_ok_o   = f3_ok && !misaligned;
    end

    // Each byte lane takes the store byte at the same position modulo the access size.
    always_comb begin
        st_bus_o = '0;
        for (int b = 0; b < NB; b++) begin
            int lane;
            lane = b & ((1 << req_funct3_i[1:0]) - 1) & (NB - 1);
            st_bus_o[b*8 +: 8] = req_wdata_i[lane*8 +: 8];
        end
        mask8    = strb_mask(req_funct3_i[1:0]);
        st_sel_o = mask8[NB-1:0] << req_off_i;
    end

    always_comb begin
        shifted = ld_bus_i >> {ld_off_i, 3'b000};
        b_s     = shifted[7:0];
        h_s     = shifted[15:0];
        w_s     = shifted[31:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = DATA_W'(b_s);
            F3_H:    ld_data_o = DATA_W'(h_s);
            F3_W:    ld_data_o = DATA_W'(w_s);
            F3_BU:   ld_data_o = DATA_W'(shifted[7:0]);
            F3_HU:   ld_data_o = DATA_W'(shifted[15:0]);
            F3_WU:   ld_data_o = DATA_W'(shifted[31:0]);
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: accepts one CPU access, runs it on a strobe/ack
// data bus with a wait-cycle timeout, and returns a one-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic   clk,
    input  logic   rst,
    lsu_if.slave   io,
    output logic   busy
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    lsu_state_e        state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [OFF_W-1:0]  ld_off_q, ld_off_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic [NB-1:0]     sel_q, sel_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              req_ok;
    logic [DATA_W-1:0] st_bus;
    logic [NB-1:0]     st_sel;
    logic [DATA_W-1:0] ld_data;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .req_write_i  (io.req_write),
        .req_funct3_i (io.req_funct3),
        .req_off_i    (io.req_addr[OFF_W-1:0]),
        .req_wdata_i  (io.req_wdata),
        .req_ok_o     (req_ok),
        .st_bus_o     (st_bus),
        .st_sel_o     (st_sel),
        .ld_funct3_i  (ld_f3_q),
        .ld_off_i     (ld_off_q),
        .ld_bus_i     (io.data_bus_i),
        .ld_data_o    (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        ld_f3_d      = ld_f3_q;
        ld_off_d     = ld_off_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        adr_d        = adr_q;
        bus_d        = bus_q;
        sel_d        = sel_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (io.req_valid) begin
                    if (req_ok) begin
                        state_d  = ST_BUS;
                        wait_d   = '0;
                        rd_d     = !io.req_write;
                        wr_d     = io.req_write;
                        adr_d    = {io.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_d    = st_bus;
                        sel_d    = st_sel;
                        ld_f3_d  = io.req_funct3;
                        ld_off_d = io.req_addr[OFF_W-1:0];
                    end else begin
                        state_d      = ST_ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            ST_BUS: begin
                if (io.data_good) begin
                    state_d      = ST_IDLE;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rd_q ? ld_data : '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                    // The cycle that brings the counter to TIMEOUT is the last one on the bus.
                    if (wait_q == TO_W'(TIMEOUT - 1)) begin
                        state_d      = ST_ERR;
                        rd_d         = 1'b0;
                        wr_d         = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            ld_f3_q      <= '0;
            ld_off_q     <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            adr_q        <= '0;
            bus_q        <= '0;
            sel_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            adr_q        <= adr_d;
            bus_q        <= bus_d;
            sel_q        <= sel_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign io.req_ready  = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign io.data_read  = rd_q;
    assign io.data_write = wr_q;
    assign io.data_adr_o = adr_q;
    assign io.data_bus_o = bus_q;
    assign io.data_sel_o = sel_q;
    assign io.resp_valid = resp_valid_q;
    assign io.resp_err   = resp_err_q;
    assign io.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit (32-bit bus, TIMEOUT=4).
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_chk = 0;
    int   n_bad = 0;

    lsu_if #(.ADDR_W(32), .DATA_W(32)) io ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .io   (io.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the inputs.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        io.req_valid  = 1'b1;
        io.req_write  = wr;
        io.req_funct3 = f3;
        io.req_addr   = a;
        io.req_wdata  = wd;
        tick();
        io.req_valid  = 1'b0;
        io.req_write  = ~wr;
        io.req_funct3 = 3'b111;
        io.req_addr   = 32'hFFFF_FFFF;
        io.req_wdata  = 32'h5A5A_5A5A;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] busv, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        chk({tag, ".rd"}, io.data_read, 1);
        io.data_good  = 1'b1;
        io.data_bus_i = busv;
        tick();
        io.data_good  = 1'b0;
        io.data_bus_i = 32'h0BAD_0BAD;
        chk({tag, ".vld"}, io.resp_valid, 1);
        chk({tag, ".err"}, io.resp_err, 0);
        chk({tag, ".data"}, io.resp_rdata, exp);
        tick();
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] esel,
                             input logic [31:0] ebus, input logic [31:0] eadr);
        issue(1'b1, f3, a, wd);
        chk({tag, ".wr"}, io.data_write, 1);
        chk({tag, ".rd"}, io.data_read, 0);
        chk({tag, ".sel"}, io.data_sel_o, esel);
        chk({tag, ".bus"}, io.data_bus_o, ebus);
        chk({tag, ".adr"}, io.data_adr_o, eadr);
        io.data_good = 1'b1;
        tick();
        io.data_good = 1'b0;
        chk({tag, ".vld"}, io.resp_valid, 1);
        chk({tag, ".err"}, io.resp_err, 0);
        chk({tag, ".data"}, io.resp_rdata, 0);
        tick();
    endtask

    task automatic err_chk(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a);
        issue(wr, f3, a, 32'h1111_2222);
        chk({tag, ".vld"}, io.resp_valid, 1);
        chk({tag, ".err"}, io.resp_err, 1);
        chk({tag, ".strb"}, {io.data_read, io.data_write}, 2'b00);
        chk({tag, ".rdy"}, io.req_ready, 0);
        tick();
        chk({tag, ".vld0"}, io.resp_valid, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        rst           = 1'b1;
        io.req_valid  = 1'b0;
        io.req_write  = 1'b0;
        io.req_funct3 = 3'b000;
        io.req_addr   = 32'h0;
        io.req_wdata  = 32'h0;
        io.data_bus_i = 32'h0;
        io.data_good  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst.ready", io.req_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.strb", {io.data_read, io.data_write}, 2'b00);
        chk("rst.adr", io.data_adr_o, 0);
        chk("rst.sel", io.data_sel_o, 0);
        chk("rst.resp", {io.resp_valid, io.resp_err}, 2'b00);
        chk("rst.rdata", io.resp_rdata, 0);

        // LW at 0x100, data_good in cycle 3
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        chk("lw.rd", io.data_read, 1);
        chk("lw.adr", io.data_adr_o, 32'h0000_0100);
        chk("lw.sel", io.data_sel_o, 4'hF);
        chk("lw.busy", busy, 1);
        chk("lw.rdy", io.req_ready, 0);
        tick();
        chk("lw.c2.rd", io.data_read, 1);
        chk("lw.c2.vld", io.resp_valid, 0);
        tick();
        io.data_good  = 1'b1;
        io.data_bus_i = 32'h8000_00F0;
        tick();
        io.data_good  = 1'b0;
        io.data_bus_i = 32'h0;
        chk("lw.vld", io.resp_valid, 1);
        chk("lw.err", io.resp_err, 0);
        chk("lw.data", io.resp_rdata, 32'h8000_00F0);
        chk("lw.rd0", io.data_read, 0);
        chk("lw.rdy1", io.req_ready, 1);
        tick();
        chk("lw.pulse", io.resp_valid, 0);
        chk("lw.hold", io.resp_rdata, 32'h8000_00F0);

        load_chk("lb103", 3'b000, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80);
        load_chk("lbu103", 3'b100, 32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0080);
        load_chk("lb101", 3'b000, 32'h0000_0101, 32'h1234_5678, 32'h0000_0056);
        load_chk("lh102", 3'b001, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF);
        load_chk("lhu102", 3'b101, 32'h0000_0102, 32'h80FF_1234, 32'h0000_80FF);
        load_chk("lh100", 3'b001, 32'h0000_0100, 32'h80FF_7234, 32'h0000_7234);

        store_chk("sh202", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h0000_0200);
        store_chk("sb201", 3'b000, 32'h0000_0201, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0200);
        store_chk("sw300", 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0300);

        err_chk("lw101", 1'b0, 3'b010, 32'h0000_0101);
        err_chk("f3_111", 1'b0, 3'b111, 32'h0000_0100);
        err_chk("ld32", 1'b0, 3'b011, 32'h0000_0100);
        err_chk("st_f3_100", 1'b1, 3'b100, 32'h0000_0100);
        err_chk("sh201", 1'b1, 3'b001, 32'h0000_0201);

        // data_good while idle must not produce a response
        io.data_good = 1'b1;
        tick();
        io.data_good = 1'b0;
        chk("idle_good.vld", io.resp_valid, 0);
        chk("idle_good.busy", busy, 0);

        // Timeout after 4 BUS cycles
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tick();
        tick();
        tick();
        chk("to.c4.rd", io.data_read, 1);
        chk("to.c4.vld", io.resp_valid, 0);
        tick();
        chk("to.vld", io.resp_valid, 1);
        chk("to.err", io.resp_err, 1);
        chk("to.rd0", io.data_read, 0);
        tick();
        chk("to.busy0", busy, 0);
        chk("to.vld0", io.resp_valid, 0);

        // Back-to-back: a new request is taken in the response cycle
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        io.data_good  = 1'b1;
        io.data_bus_i = 32'h1357_9BDF;
        tick();
        io.data_good  = 1'b0;
        chk("b2b.vld", io.resp_valid, 1);
        chk("b2b.data", io.resp_rdata, 32'h1357_9BDF);
        issue(1'b0, 3'b100, 32'h0000_0102, 32'h0);
        chk("b2b.rd", io.data_read, 1);
        chk("b2b.vld0", io.resp_valid, 0);
        io.data_good  = 1'b1;
        io.data_bus_i = 32'h0042_0000;
        tick();
        io.data_good  = 1'b0;
        chk("b2b.data2", io.resp_rdata, 32'h0000_0042);
        tick();

        // Reset mid-BUS aborts silently, then a normal LW
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        chk("rb.rd", io.data_read, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb.strb", {io.data_read, io.data_write}, 2'b00);
        chk("rb.adr", io.data_adr_o, 0);
        chk("rb.sel", io.data_sel_o, 0);
        chk("rb.vld", io.resp_valid, 0);
        chk("rb.rdata", io.resp_rdata, 0);
        chk("rb.rdy", io.req_ready, 1);
        tick();
        chk("rb.vld2", io.resp_valid, 0);
        load_chk("rb.lw", 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the bus data width, restricted to 32 or 64.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum bus wait cycles before abort.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic uses the rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1, CPU request present.
REQ-007 The block SHALL have port req_ready, output, 1, request accepted this cycle when req_valid is also high.
REQ-008 The block SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-009 The block SHALL have port req_funct3, input, 3, RISC-V access size and sign.
REQ-010 The block SHALL have port req_addr, input, ADDR_W, byte address (rs1+imm).
REQ-011 The block SHALL have port req_wdata, input, DATA_W, store data, LSB-aligned.
REQ-012 The block SHALL have ports data_read and data_write, output, 1 each, bus strobes.
REQ-013 The block SHALL have port data_adr_o, output, ADDR_W, bus address, aligned down to DATA_W/8.
REQ-014 The block SHALL have port data_bus_o, output, DATA_W, lane-steered store data.
REQ-015 The block SHALL have port data_sel_o, output, DATA_W/8, byte enables.
REQ-016 The block SHALL have port data_bus_i, input, DATA_W, bus read data.
REQ-017 The block SHALL have port data_good, input, 1, bus completion.
REQ-018 The block SHALL have ports resp_valid (output, 1), resp_rdata (output, DATA_W) and resp_err (output, 1), the one-cycle response.
REQ-019 The block SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, BUS and ERR.
REQ-021 req_ready SHALL equal 1 only in IDLE.
REQ-022 Acceptance SHALL latch addr, write, funct3 and wdata; later changes to the req_* inputs have no effect until the next acceptance.
REQ-023 The legal funct3 codes SHALL be loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, plus 011 LD and 110 LWU when DATA_W=64; and stores 000, 001, 010, plus 011 when DATA_W=64.
REQ-024 An accepted request with an illegal funct3, or whose address is not naturally aligned to its access size, SHALL go to ERR with no bus strobe.
REQ-025 ERR SHALL last one cycle and return to IDLE while emitting resp_valid=1 and resp_err=1 in that cycle.
REQ-026 A legal request accepted in cycle 0 SHALL drive data_read or data_write high from cycle 1 in state BUS, with data_adr_o, data_bus_o and data_sel_o stable until completion.
REQ-027 The block SHALL sample data_good only in BUS; data_good in IDLE or ERR is ignored.
REQ-028 When data_good is sampled high in cycle k, the block SHALL in cycle k+1 drop both strobes, return to IDLE, assert req_ready, and pulse resp_valid for exactly one cycle with resp_err=0.
REQ-029 Load data SHALL be the addressed lane of data_bus_i captured at cycle k, shifted to the LSB, sign-extended for LB/LH/LW(64-bit) and zero-extended for LBU/LHU/LWU.
REQ-030 For stores, resp_rdata SHALL be 0.
REQ-031 Store data SHALL be replicated across all lanes of its size, and data_sel_o SHALL be the size mask shifted by the offset bits of req_addr.
REQ-032 A wait counter SHALL increment every BUS cycle without data_good.
REQ-033 When the wait counter reaches TIMEOUT, the block SHALL drop the strobes next cycle and respond with resp_err=1.
REQ-034 A response cycle SHALL also be able to accept a new request, giving back-to-back throughput of one access per 2+wait cycles.
REQ-035 resp_rdata SHALL hold its value until the next response.

Reset
REQ-036 When rst is high at a rising edge, the block SHALL force the state to IDLE, clear the wait counter, and drive data_read, data_write, data_adr_o, data_bus_o, data_sel_o, resp_valid, resp_rdata and resp_err to 0; req_ready shall then be 1.
REQ-037 Reset during BUS SHALL abort the access with no response.

Structure
REQ-038 Package lsu_pkg SHALL hold the state enum, the funct3 constants and the strobe-mask function.
REQ-039 Combinational lane steering, byte-enable generation and load extension SHALL be one sub-module, lsu_align.

Verification
REQ-040 LW at 0x100 with data_good at cycle 3 and bus 0x8000_00F0 SHALL give a resp_valid pulse at cycle 4 with rdata 0x8000_00F0 and err 0.
REQ-041 LB at 0x103 with bus 0x80FF_FFFF SHALL give rdata 0xFFFF_FF80; LBU at the same address SHALL give 0x0000_0080.
REQ-042 SH at 0x202 with wdata 0x1234_ABCD SHALL drive sel 4'b1100, bus 0xABCD_ABCD and adr 0x200.
REQ-043 LW at 0x101 SHALL produce err at cycle 1 with no strobe; funct3 111 SHALL also produce err.
REQ-044 With TIMEOUT=4 and data_good never asserted, the block SHALL give err after 4 BUS cycles and busy shall return to 0.
REQ-045 rst asserted mid-BUS SHALL clear all outputs next cycle with no resp_valid, and a following LW shall complete normally.
